// File: rtl/piso_serializer_pkg.sv
// Shared encodings for the shift-register family (serializer and serial-in blocks).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package piso_serializer_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

endpackage

// File: rtl/shift_bit_counter.sv
// Bit-position counter for the serializer: counts 0..WIDTH-1 and saturates there.
// Latency: count updates one clock after an enabled edge; at_max is combinational from count.
// Backpressure: none; enable low holds the count.
module shift_bit_counter
   import piso_serializer_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     enable,
   input  logic                     clear,
   output logic [$clog2(WIDTH)-1:0] count,
   output logic                     at_max
);

   localparam int CW = $clog2(WIDTH);

   assign at_max = (count == CW'(WIDTH - 1));

   // Clear wins over increment; the count saturates so a stalled final bit stays at_max.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (enable) begin
         if (clear) begin
            count <= '0;
         end else if (!at_max) begin
            count <= count + 1'b1;
         end
      end
   end

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out shifter: emits a WIDTH-bit word MSB first with valid/last flags.
// Latency: first bit on out one clock after the accepting edge; back-to-back words have no gap.
// Backpressure: load_ready only in IDLE or on the final bit; enable low stalls everything.
module piso_serializer
   import piso_serializer_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic [WIDTH-1:0] data_in,
   input  logic             load_valid,
   output logic             load_ready,
   output logic             out,
   output logic             out_valid,
   output logic             out_last
);

   localparam int CW = $clog2(WIDTH);

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] sreg;
   logic [WIDTH-1:0] sreg_nxt;
   logic [CW-1:0]    cnt;
   logic             at_max;
   logic             accept;
   logic             cnt_en;
   logic             cnt_clear;

   // Ready is held low during reset so nothing is offered to a block that is being cleared.
   assign load_ready = enable & ~reset &
                       ((state == IDLE) | ((state == SHIFT) & at_max));
   assign accept     = load_ready & load_valid;

   // The counter restarts on every new word and also when a word ends without a successor.
   assign cnt_en    = enable & (accept | (state == SHIFT));
   assign cnt_clear = accept | at_max;

   shift_bit_counter #(
      .WIDTH (WIDTH)
   ) u_cnt (
      .clk    (clk),
      .reset  (reset),
      .enable (cnt_en),
      .clear  (cnt_clear),
      .count  (cnt),
      .at_max (at_max)
   );

   // Next-state and next shift-register contents; nothing moves while enable is low.
   always_comb begin
      state_nxt = state;
      sreg_nxt  = sreg;
      if (enable) begin
         case (state)
            IDLE: begin
               if (accept) begin
                  state_nxt = SHIFT;
                  sreg_nxt  = data_in;
               end
            end
            SHIFT: begin
               if (at_max) begin
                  if (accept) begin
                     sreg_nxt = data_in;
                  end else begin
                     state_nxt = IDLE;
                     sreg_nxt  = '0;
                  end
               end else begin
                  sreg_nxt = {sreg[WIDTH-2:0], 1'b0};
               end
            end
            default: begin
               state_nxt = IDLE;
               sreg_nxt  = '0;
            end
         endcase
      end
   end

   // State and shift register; reset abandons any word in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         sreg  <= '0;
      end else begin
         state <= state_nxt;
         sreg  <= sreg_nxt;
      end
   end

   // out comes straight from the MSB flop; the flags decode registered state only.
   assign out       = sreg[WIDTH-1];
   assign out_valid = (state == SHIFT);
   assign out_last  = (state == SHIFT) & at_max;

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench for piso_serializer: directed scenarios plus randomized traffic.
// Reference model is a queue of pending serial bits, popped once per enabled clock.
// A loopback serial-in register rebuilds words from out while out_valid is high.
module tb_piso_serializer;

   localparam int WIDTH = 8;

   logic             clk = 1'b0;
   logic             reset;
   logic             enable;
   logic [WIDTH-1:0] data_in;
   logic             load_valid;
   logic             load_ready;
   logic             out;
   logic             out_valid;
   logic             out_last;

   int nchk  = 0;
   int nfail = 0;

   bit q[$];

   logic [WIDTH-1:0] sipo;

   logic s_out, s_vld, s_last, s_rdy;

   piso_serializer #(.WIDTH(WIDTH)) dut (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .data_in    (data_in),
      .load_valid (load_valid),
      .load_ready (load_ready),
      .out        (out),
      .out_valid  (out_valid),
      .out_last   (out_last)
   );

   always #5 clk = ~clk;

   // Serial-in left-shift receiver fed from the serializer output.
   always @(posedge clk or posedge reset) begin
      if (reset)
         sipo <= '0;
      else if (enable && out_valid)
         sipo <= {sipo[WIDTH-2:0], out};
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nchk++;
      if (got !== exp) begin
         nfail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Called at a falling edge: drive, compare against the model, take the rising edge,
   // advance the model, return at the next falling edge.
   task automatic step(input logic en, input logic lv, input logic [WIDTH-1:0] d);
      logic e_rdy;
      enable     = en;
      load_valid = lv;
      data_in    = d;
      #1;
      e_rdy = en && (q.size() <= 1);
      s_out  = out;
      s_vld  = out_valid;
      s_last = out_last;
      s_rdy  = load_ready;
      chk("out",        out,        (q.size() > 0) ? q[0] : 1'b0);
      chk("out_valid",  out_valid,  q.size() > 0);
      chk("out_last",   out_last,   q.size() == 1);
      chk("load_ready", load_ready, e_rdy);
      @(posedge clk);
      if (en) begin
         if (q.size() > 0) void'(q.pop_front());
         if (e_rdy && lv)
            for (int i = WIDTH - 1; i >= 0; i--) q.push_back(d[i]);
      end
      @(negedge clk);
   endtask

   // Asynchronous reset pulse raised between edges; outputs must drop at once.
   task automatic async_reset();
      #2;
      enable = 1'b1;
      reset  = 1'b1;
      #1;
      chk("rst_out",   out,        0);
      chk("rst_vld",   out_valid,  0);
      chk("rst_last",  out_last,   0);
      chk("rst_rdy",   load_ready, 0);
      q.delete();
      load_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic send_word(input logic [WIDTH-1:0] w, output logic [WIDTH-1:0] bits,
                            output int nvld, output int last_pos);
      bits = '0; nvld = 0; last_pos = -1;
      step(1'b1, 1'b1, w);
      for (int i = 0; i < WIDTH + 2; i++) begin
         step(1'b1, 1'b0, $urandom);
         if (s_vld) begin
            bits = {bits[WIDTH-2:0], s_out};
            nvld++;
         end
         if (s_last) last_pos = i;
         if (i == WIDTH) chk("loopback", sipo, w);
      end
   endtask

   initial begin
      logic [WIDTH-1:0] bits;
      logic [15:0]      bits16;
      logic [4:0]       bits5;
      int               nvld, last_pos, nrdy;
      logic [WIDTH-1:0] words[3];

      reset = 1'b1; enable = 1'b1; load_valid = 1'b1; data_in = 8'hFF;
      #1;
      chk("reset_out",  out,        0);
      chk("reset_vld",  out_valid,  0);
      chk("reset_last", out_last,   0);
      chk("reset_rdy",  load_ready, 0);
      load_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;

      // Single word, MSB first, flags and return to idle.
      send_word(8'b11010110, bits, nvld, last_pos);
      chk("w1_bits", bits, 8'b11010110);
      chk("w1_nvld", nvld, 8);
      chk("w1_last", last_pos, 7);

      // Back-to-back words with load_valid held high.
      bits16 = '0; nrdy = 0;
      step(1'b1, 1'b1, 8'hA5);
      for (int i = 0; i < 16; i++) begin
         step(1'b1, (i < 8), 8'h3C);
         chk("b2b_vld", s_vld, 1);
         bits16 = {bits16[14:0], s_out};
         if (i < 15 && s_rdy) nrdy++;
      end
      chk("b2b_bits", bits16, 16'hA53C);
      chk("b2b_nrdy", nrdy, 1);
      step(1'b1, 1'b0, 8'h00);
      chk("b2b_idle", s_vld, 0);

      // Three-cycle enable stall after the third bit.
      step(1'b1, 1'b1, 8'hF0);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'h00);
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b1, 8'h55);
         chk("stall_out", s_out, 1);
         chk("stall_rdy", s_rdy, 0);
      end
      bits5 = '0;
      for (int i = 0; i < 5; i++) begin
         step(1'b1, 1'b0, 8'h00);
         bits5 = {bits5[3:0], s_out};
      end
      chk("stall_tail", bits5, 5'b10000);

      // Reset after the fourth bit of an all-ones word: no residue afterwards.
      step(1'b1, 1'b1, 8'hFF);
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'h00);
      async_reset();
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 1'b0, 8'h00);
         chk("post_rst_vld", s_vld, 0);
      end
      // First acceptance straight after a reset release.
      async_reset();
      send_word(8'h81, bits, nvld, last_pos);
      chk("post_rst_word", bits, 8'h81);

      // Loopback of selected words into the serial-in register.
      words[0] = 8'b11010110; words[1] = 8'h01; words[2] = 8'h80;
      for (int k = 0; k < 3; k++) begin
         send_word(words[k], bits, nvld, last_pos);
         chk("lb_bits", bits, words[k]);
      end

      // Randomized traffic with stalls, idle gaps and occasional resets.
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 59) == 0)
            async_reset();
         else
            step($urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0, $urandom);
      end

      $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
      $finish;
   end

endmodule

// File: doc/piso_serializer.md
PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning the parallel word width in bits (legal values 2 to 32).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port enable, input, 1 bit: clock-enable; when low, all state holds.
REQ-005 The block SHALL have port data_in, input, WIDTH bits: the parallel word to transmit.
REQ-006 The block SHALL have port load_valid, input, 1 bit: data_in holds a word to send.
REQ-007 The block SHALL have port load_ready, output, 1 bit: the block accepts a word this cycle.
REQ-008 The block SHALL have port out, output, 1 bit: the registered serial data bit, MSB first.
REQ-009 The block SHALL have port out_valid, output, 1 bit: out carries a valid bit this cycle.
REQ-010 The block SHALL have port out_last, output, 1 bit: out carries the final bit (LSB) of the word.

Function
REQ-011 The FSM SHALL have two states: IDLE and SHIFT, with a bit counter cnt of width ceil(log2(WIDTH)).
REQ-012 A word SHALL be accepted on a rising edge where enable, load_valid and load_ready are all 1.
- The word is copied into the internal register sreg.
- cnt is set to 0 and the state becomes SHIFT.
REQ-013 load_ready SHALL be combinational and equal to enable AND (state==IDLE OR (state==SHIFT AND cnt==WIDTH-1)).
REQ-014 out SHALL equal sreg[WIDTH-1]; after acceptance the first bit appears on out in the next cycle (latency of 1 clock).
REQ-015 On each enabled edge in SHIFT with cnt<WIDTH-1, sreg SHALL shift left by one with 0 filled at the LSB, and cnt SHALL increment by 1.
REQ-016 On the enabled edge in SHIFT with cnt==WIDTH-1:
- if load_valid=1, a new word SHALL be loaded with no gap cycle (back-to-back);
- otherwise the state SHALL go to IDLE and sreg SHALL clear to 0.
REQ-017 out_valid SHALL be 1 exactly when state==SHIFT.
REQ-018 out_last SHALL be 1 exactly when state==SHIFT and cnt==WIDTH-1.
REQ-019 In IDLE, out, out_valid and out_last SHALL all be 0.
REQ-020 While enable=0, state, sreg and cnt SHALL hold, outputs SHALL keep their values, and load_ready SHALL be 0.
REQ-021 A load_valid that is not accepted SHALL have no effect; data_in is sampled only on the accepting edge.

Reset
REQ-022 Asserting reset SHALL immediately (asynchronously) force state=IDLE, sreg=0 and cnt=0.
- Therefore out=0, out_valid=0, out_last=0 and load_ready=0 while reset is held.
REQ-023 Reset asserted mid-word SHALL abandon the word; no remaining bits are emitted after reset is released.
REQ-024 The first acceptance SHALL be possible on the first enabled edge after reset deasserts.

Structure
REQ-025 A shared header SHALL hold the state encodings (IDLE=0, SHIFT=1) and the default WIDTH constant, for reuse by the serial-in shift register blocks.
REQ-026 The bit counter SHALL be a separate sub-module shift_bit_counter, with:
- inputs clk, reset, enable, clear;
- outputs count and at_max.
REQ-027 out SHALL be driven directly from a flop with no combinational path from the inputs; only load_ready is combinational.

Verification
REQ-028 Reset, then load 8'b11010110 with enable=1 -> out = 1,1,0,1,0,1,1,0 on 8 consecutive cycles; out_valid high for exactly 8 cycles; out_last high only on the 8th; then IDLE with out=0.
REQ-029 Hold load_valid=1 with words 8'hA5 then 8'h3C -> 16 consecutive valid bits 10100101 00111100; load_ready high only in the cycle of the final bit of the first word; no gap cycle.
REQ-030 Drop enable to 0 for 3 cycles after the 3rd bit of 8'hF0 -> out holds 1 and load_ready=0 during the stall; the remaining bits 1,0,0,0,0 follow once enable returns.
REQ-031 Assert reset after the 4th bit of 8'hFF -> out, out_valid and out_last go to 0 immediately; after release the block stays IDLE with no residual bits.
REQ-032 Loop the serial output back into the 8-bit serial-in left-shift register block, enabling it only when out_valid=1 -> its parallel output equals the transmitted word (8'b11010110, 8'h01, 8'h80) on the cycle after out_last.
